// File: rtl/ram_reader_pkg.sv
// Shared types and sizing for the RAM burst reader: FSM state, FIFO depth and
// the width used for the FIFO-plus-in-flight credit sum.
package ram_reader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int FIFO_DEPTH = 3;
    localparam int COUNT_W    = $clog2(FIFO_DEPTH + 1);
    localparam int CREDIT_W   = COUNT_W + 1;

    // A read may be issued only while buffered plus in-flight words leave room.
    function automatic logic credit_ok(input logic [COUNT_W-1:0] count,
                                       input logic               inflight);
        logic [CREDIT_W-1:0] credit;
        credit = {1'b0, count} + {{(CREDIT_W-1){1'b0}}, inflight};
        return credit < CREDIT_W'(FIFO_DEPTH);
    endfunction

endpackage

// File: rtl/ram_reader_fifo.sv
// Three-entry first-word-fall-through FIFO: head always shows the oldest word,
// count reports occupancy.
module ram_reader_fifo
    import ram_reader_pkg::*;
#(
    parameter int DATA_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head,
    output logic [COUNT_W-1:0]    count
);

    localparam logic [1:0]         LAST_SLOT = 2'(FIFO_DEPTH - 1);
    localparam logic [COUNT_W-1:0] FULL      = COUNT_W'(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [1:0]            wr_ptr_q, wr_ptr_d;
    logic [1:0]            rd_ptr_q, rd_ptr_d;
    logic [COUNT_W-1:0]    count_q, count_d;
    logic                  do_push;
    logic                  do_pop;

    always_comb begin
        do_push  = push && (count_q != FULL);
        do_pop   = pop && (count_q != '0);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = (wr_ptr_q == LAST_SLOT) ? 2'd0 : wr_ptr_q + 2'd1;
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == LAST_SLOT) ? 2'd0 : rd_ptr_q + 2'd1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + COUNT_W'(1);
            2'b01:   count_d = count_q - COUNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/ram_burst_reader.sv
// Burst read master for a synchronous-read RAM, streaming words over valid/ready.
// Optional start-range checking and the err port are enabled by RAM_READER_ERR_EN.
module ram_burst_reader
    import ram_reader_pkg::*;
#(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [ADDR_WIDTH:0]   length,
    output logic                  busy,
    output logic                  done,
    output logic                  ren,
    output logic [ADDR_WIDTH-1:0] raddr,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready
`ifdef RAM_READER_ERR_EN
    ,
    output logic                  err
`endif
);

    state_t                state_q, state_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  inflight_q, inflight_d;
    logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
    logic [ADDR_WIDTH:0]   remaining_q, remaining_d;
    logic [DATA_WIDTH-1:0] fifo_head;
    logic [COUNT_W-1:0]    fifo_count;
    logic                  pop;
    logic                  last_pop;
`ifdef RAM_READER_ERR_EN
    localparam logic [ADDR_WIDTH+1:0] RAM_DEPTH = (ADDR_WIDTH+2)'(1) << ADDR_WIDTH;
    logic                  err_q, err_d;
    logic [ADDR_WIDTH+1:0] burst_end;
    logic                  out_of_range;
`endif

    ram_reader_fifo #(.DATA_WIDTH(DATA_WIDTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (inflight_q),
        .push_data (rdata),
        .pop       (pop),
        .head      (fifo_head),
        .count     (fifo_count)
    );

    assign m_valid  = (fifo_count != '0);
    assign pop      = m_valid && m_ready;
    // Last beat: nothing left in flight and this pop empties the FIFO.
    assign last_pop = pop && (fifo_count == COUNT_W'(1)) && !inflight_q;
    assign ren      = (state_q == READ) && credit_ok(fifo_count, inflight_q);

    always_comb begin
`ifdef RAM_READER_ERR_EN
        burst_end    = {2'b00, start_addr} + {1'b0, length};
        out_of_range = burst_end > RAM_DEPTH;
        err_d        = 1'b0;
`endif
        state_d     = state_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        raddr_d     = raddr_q;
        remaining_d = remaining_q;
        inflight_d  = ren;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (length == '0) begin
                        done_d = 1'b1;
                    end
`ifdef RAM_READER_ERR_EN
                    else if (out_of_range) begin
                        err_d  = 1'b1;
                        done_d = 1'b1;
                    end
`endif
                    else begin
                        state_d     = READ;
                        busy_d      = 1'b1;
                        raddr_d     = start_addr;
                        remaining_d = length;
                    end
                end
            end
            READ: begin
                if (ren) begin
                    raddr_d     = raddr_q + ADDR_WIDTH'(1);
                    remaining_d = remaining_q - (ADDR_WIDTH+1)'(1);
                    if (remaining_q == (ADDR_WIDTH+1)'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (last_pop) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            inflight_q  <= 1'b0;
            raddr_q     <= '0;
            remaining_q <= '0;
`ifdef RAM_READER_ERR_EN
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            inflight_q  <= inflight_d;
            raddr_q     <= raddr_d;
            remaining_q <= remaining_d;
`ifdef RAM_READER_ERR_EN
            err_q       <= err_d;
`endif
        end
    end

    // Gate the head so idle or freshly reset output never shows stale storage.
    assign m_data = m_valid ? fifo_head : '0;
    assign busy   = busy_q;
    assign done   = done_q;
    assign raddr  = raddr_q;
`ifdef RAM_READER_ERR_EN
    assign err    = err_q;
`endif

endmodule

// File: tb/tb_ram_burst_reader.sv
// Bench for ram_burst_reader paired with a synchronous-read RAM model preloaded
// with mem[i]=i; expected beats go into a queue checked by a separate monitor.
module tb_ram_burst_reader;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [5:0] start_addr;
    logic [6:0] length;
    logic       busy;
    logic       done;
    logic       ren;
    logic [5:0] raddr;
    logic [5:0] rdata;
    logic [5:0] m_data;
    logic       m_valid;
    logic       m_ready;
`ifdef RAM_READER_ERR_EN
    logic       err;
`endif

    int         total;
    int         bad;
    int         issued;
    int         popped;
    int         ready_mode;
    int         ready_phase;
    logic [5:0] exp_q [$];
    logic [5:0] mem [64];
    logic       prev_stall;
    logic [5:0] prev_data;

    ram_burst_reader #(.ADDR_WIDTH(6), .DATA_WIDTH(6)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .start_addr (start_addr),
        .length     (length),
        .busy       (busy),
        .done       (done),
        .ren        (ren),
        .raddr      (raddr),
        .rdata      (rdata),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready)
`ifdef RAM_READER_ERR_EN
        ,
        .err        (err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read RAM model, same clock as the reader.
    always @(posedge clk) begin
        if (ren) rdata <= mem[raddr];
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Downstream ready: always high, or high one cycle in three.
    initial begin
        m_ready = 1'b1;
        ready_phase = 0;
        forever begin
            @(posedge clk);
            #1;
            ready_phase++;
            m_ready = (ready_mode == 0) ? 1'b1 : ((ready_phase % 3) == 0);
        end
    end

    // Monitor: pops the scoreboard on each handshake, checks hold and credit.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", int'(m_valid), 1);
                check("hold_data", int'(m_data), int'(prev_data));
            end
            if (ren) begin
                issued++;
                check("credit_le3", int'((issued - popped) <= 3), 1);
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL extra_beat got=%0d want=none at %0t", m_data, $time);
                end else begin
                    check("beat", int'(m_data), int'(exp_q.pop_front()));
                end
                popped++;
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
        end
    end

    task automatic start_cmd(input logic [5:0] addr, input logic [6:0] len);
        @(posedge clk);
        #1;
        issued     = 0;
        popped     = 0;
        start      = 1'b1;
        start_addr = addr;
        length     = len;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc, input string name);
        logic seen;
        seen = 1'b0;
        for (int n = 0; n < max_cyc && !seen; n++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check(name, int'(seen), 1);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_ren"}, int'(ren), 0);
        check({tag, "_raddr"}, int'(raddr), 0);
        check({tag, "_valid"}, int'(m_valid), 0);
        check({tag, "_data"}, int'(m_data), 0);
`ifdef RAM_READER_ERR_EN
        check({tag, "_err"}, int'(err), 0);
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] wrap_addr [4];
        total = 0; bad = 0; issued = 0; popped = 0;
        ready_mode = 0;
        prev_stall = 1'b0;
        prev_data  = '0;
        start = 1'b0; start_addr = '0; length = '0;
        for (int i = 0; i < 64; i++) mem[i] = 6'(i);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_idle_outputs("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Burst addr=5 len=4 with ready high: exact cycle-by-cycle timing.
        for (int i = 5; i <= 8; i++) exp_q.push_back(6'(i));
        start_cmd(6'd5, 7'd4);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            check("t1_ren", int'(ren), int'(k <= 4));
            if (k <= 4) check("t1_raddr", int'(raddr), 4 + k);
            check("t1_valid", int'(m_valid), int'(k >= 3 && k <= 6));
            check("t1_done", int'(done), int'(k == 7));
            check("t1_busy", int'(busy), int'(k <= 6));
        end

        // Burst crossing the top of memory.
        wrap_addr[0] = 6'd62; wrap_addr[1] = 6'd63; wrap_addr[2] = 6'd0; wrap_addr[3] = 6'd1;
`ifdef RAM_READER_ERR_EN
        start_cmd(6'd62, 7'd4);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check("t2_err", int'(err), int'(k == 1));
            check("t2_done", int'(done), int'(k == 1));
            check("t2_ren", int'(ren), 0);
            check("t2_valid", int'(m_valid), 0);
            check("t2_busy", int'(busy), 0);
        end
`else
        for (int i = 0; i < 4; i++) exp_q.push_back(wrap_addr[i]);
        start_cmd(6'd62, 7'd4);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check("t2_ren", int'(ren), 1);
            check("t2_raddr", int'(raddr), int'(wrap_addr[k-1]));
        end
        wait_done(10, "t2_done");
`endif

        // Full-depth burst under 1-in-3 ready, with a stray start while busy.
        ready_mode = 1;
        for (int i = 0; i < 64; i++) exp_q.push_back(6'(i));
        start_cmd(6'd0, 7'd64);
        repeat (10) @(posedge clk);
        #1;
        start = 1'b1; start_addr = 6'd40; length = 7'd3;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(400, "t4_done");
        check("t4_busy_at_done", int'(busy), 0);
        ready_mode = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("t4_quiet_ren", int'(ren), 0);
            check("t4_quiet_done", int'(done), 0);
        end

        // Zero-length start.
        start_cmd(6'd7, 7'd0);
        for (int k = 1; k <= 2; k++) begin
            @(negedge clk);
            check("t5_done", int'(done), int'(k == 1));
            check("t5_busy", int'(busy), 0);
            check("t5_ren", int'(ren), 0);
        end

        // Reset during the third beat of a len=8 burst, then a clean len=2 burst.
        exp_q.push_back(6'd0);
        exp_q.push_back(6'd1);
        start_cmd(6'd0, 7'd8);
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1 check_idle_outputs("midrst");
        @(posedge clk);
        #1 rst_n = 1'b1;
        check("t6_queue_after_reset", exp_q.size(), 0);
        exp_q.push_back(6'd0);
        exp_q.push_back(6'd1);
        start_cmd(6'd0, 7'd2);
        wait_done(20, "t6_done");
        repeat (3) @(negedge clk);
        check("final_queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
